// File: rtl/cdb_broadcaster_pkg.sv
// Shared constants for the common data bus producer: tag width, payload width
// and default result-queue depth.
package cdb_broadcaster_pkg;

  localparam int CDB_ROB_INDEX_BIT = 4;
  localparam int CDB_DATA_BIT      = 32;
  localparam int CDB_QUEUE_DEPTH   = 8;

endpackage

// File: rtl/cdb_queue.sv
// Circular FIFO of {rob_id, val} results: up to two writes and one read per
// cycle, with a synchronous flush that empties it.
module cdb_queue
  import cdb_broadcaster_pkg::*;
#(
  parameter int DEPTH = CDB_QUEUE_DEPTH,
  parameter int WIDTH = CDB_ROB_INDEX_BIT + CDB_DATA_BIT
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush,
  input  logic                       wr0_en,
  input  logic [WIDTH-1:0]           wr0_data,
  input  logic                       wr1_en,
  input  logic [WIDTH-1:0]           wr1_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_plus1;

  assign tail_plus1 = tail + 1'b1;
  assign head_data  = mem[head];

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only add reset fanout.
  always_ff @(posedge clk_in) begin
    if (wr0_en) mem[tail]       <= wr0_data;
    if (wr1_en) mem[tail_plus1] <= wr1_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(rd_en);
      tail  <= tail + PTR_W'(wr0_en) + PTR_W'(wr1_en);
      count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Producer end of the CDB: merges ALU and LSB results with the backlog queue
// and registers one broadcast per cycle, oldest result first.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int QUEUE_DEPTH   = CDB_QUEUE_DEPTH,
  parameter int ROB_INDEX_BIT = CDB_ROB_INDEX_BIT
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         clear,
  input  logic                         alu_ready,
  input  logic [ROB_INDEX_BIT-1:0]     alu_rob_id,
  input  logic [31:0]                  alu_result,
  input  logic                         lsb_valid,
  input  logic [ROB_INDEX_BIT-1:0]     lsb_rob_id,
  input  logic [31:0]                  lsb_result,
  output logic                         lsb_ready,
  output logic                         cdb_req,
  output logic [ROB_INDEX_BIT-1:0]     cdb_rob_id,
  output logic [31:0]                  cdb_val,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W = ROB_INDEX_BIT + 32;

  logic               active;
  logic               alu_fire;
  logic               lsb_fire;
  logic               flush;
  logic [ENTRY_W-1:0] alu_entry;
  logic [ENTRY_W-1:0] lsb_entry;
  logic [ENTRY_W-1:0] head_data;
  logic               sel_valid;
  logic [ENTRY_W-1:0] sel_data;
  logic               rd_en;
  logic               wr0_en;
  logic [ENTRY_W-1:0] wr0_data;
  logic               wr1_en;

  assign active    = rdy_in & ~clear;
  assign flush     = rdy_in & clear;
  // Refusing the LSB one entry early leaves room for an ALU result every cycle.
  assign lsb_ready = active & (queue_count < CNT_W'(QUEUE_DEPTH - 1));
  assign alu_fire  = active & alu_ready;
  assign lsb_fire  = lsb_valid & lsb_ready;
  assign alu_entry = {alu_rob_id, alu_result};
  assign lsb_entry = {lsb_rob_id, lsb_result};

  // NOTE: every output gets a default before the branches so this block
  // stays purely combinational and infers no latches.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = head_data;
    rd_en     = 1'b0;
    wr0_en    = 1'b0;
    wr0_data  = alu_entry;
    wr1_en    = 1'b0;
    if (active) begin
      if (queue_count != '0) begin
        // Backlog goes first; both new arrivals join the tail, ALU ahead of LSB.
        sel_valid = 1'b1;
        rd_en     = 1'b1;
        wr0_en    = alu_fire | lsb_fire;
        wr0_data  = alu_fire ? alu_entry : lsb_entry;
        wr1_en    = alu_fire & lsb_fire;
      end else if (alu_fire) begin
        sel_valid = 1'b1;
        sel_data  = alu_entry;
        wr0_en    = lsb_fire;
        wr0_data  = lsb_entry;
      end else if (lsb_fire) begin
        sel_valid = 1'b1;
        sel_data  = lsb_entry;
      end
    end
  end

  cdb_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .flush     (flush),
    .wr0_en    (wr0_en),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_data  (lsb_entry),
    .rd_en     (rd_en),
    .head_data (head_data),
    .count     (queue_count)
  );

  // Tag and value hold when idle; only cdb_req marks a fresh broadcast.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_req    <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
    end else if (rdy_in) begin
      cdb_req <= sel_valid;
      if (sel_valid) {cdb_rob_id, cdb_val} <= sel_data;
    end
  end

endmodule
